// File: rtl/core_pipe_exec_mdu.sv
// Iterative RV64M multiply/divide unit for the EX stage.
// Shift-add multiplier (MUL_BPC bits/cycle) and restoring divider, one op at a time.
module core_pipe_exec_mdu #(
   parameter int XLEN    = 64,
   parameter int MUL_BPC = 1
) (
   input  logic            g_clk,
   input  logic            g_reset,
   input  logic            mdu_valid,
   input  logic            mdu_flush,
   input  logic            mdu_op_mul,
   input  logic            mdu_op_mulh,
   input  logic            mdu_op_mulhsu,
   input  logic            mdu_op_mulhu,
   input  logic            mdu_op_div,
   input  logic            mdu_op_divu,
   input  logic            mdu_op_rem,
   input  logic            mdu_op_remu,
   input  logic            mdu_word,
   input  logic [XLEN-1:0] mdu_opr_a,
   input  logic [XLEN-1:0] mdu_opr_b,
   output logic            mdu_ready,
   output logic [XLEN-1:0] mdu_result
);

   // state   | meaning
   // IDLE    | waiting for an op; ready when no op is selected
   // MUL     | shift-add iterations
   // DIV     | restoring-division iterations
   // DONE    | result valid, ready pulses for one cycle
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]        state;
   logic [6:0]        cnt;
   logic [2*XLEN-1:0] m_acc, m_mcand;
   logic [XLEN-1:0]   m_mplr, d_quo, d_rem, d_dvsr;
   logic              neg_q, neg_r;

   // Word-mode extension from bit 31; a no-op outside word mode.
   function automatic logic [XLEN-1:0] ext_w(input logic [XLEN-1:0] v, input logic wd,
                                             input logic sx);
      logic [XLEN-1:0] r;
      r = v;
      if (wd) for (int i = 32; i < XLEN; i++) r[i] = sx & v[31];
      return r;
   endfunction

   logic is_mul, is_div, any_sel, word_md, sgn_a, sgn_b, is_quo, abort;
   assign is_mul  = mdu_op_mul | mdu_op_mulh | mdu_op_mulhsu | mdu_op_mulhu;
   assign is_div  = mdu_op_div | mdu_op_divu | mdu_op_rem | mdu_op_remu;
   assign any_sel = is_mul | is_div;
   assign word_md = mdu_word && (XLEN > 32);
   assign sgn_a   = mdu_op_mulh | mdu_op_mulhsu | mdu_op_div | mdu_op_rem;
   assign sgn_b   = mdu_op_mulh | mdu_op_div | mdu_op_rem;
   assign is_quo  = mdu_op_div | mdu_op_divu;
   assign abort   = mdu_flush || ((state != ST_IDLE) && !mdu_valid);

   assign mdu_ready = (state == ST_DONE) || ((state == ST_IDLE) && !any_sel);

   logic [XLEN-1:0] a_sx, b_sx, a_mag, b_mag, msb_w, spec_res;
   logic            a_neg, b_neg, div_zero, div_ovf;

   always_comb begin
      a_sx     = ext_w(mdu_opr_a, word_md, 1'b1);
      b_sx     = ext_w(mdu_opr_b, word_md, 1'b1);
      a_neg    = sgn_a & (word_md ? mdu_opr_a[31] : mdu_opr_a[XLEN-1]);
      b_neg    = sgn_b & (word_md ? mdu_opr_b[31] : mdu_opr_b[XLEN-1]);
      a_mag    = ext_w(a_neg ? -a_sx : a_sx, word_md, 1'b0);
      b_mag    = ext_w(b_neg ? -b_sx : b_sx, word_md, 1'b0);
      msb_w    = XLEN'(1) << (word_md ? 31 : XLEN - 1);
      div_zero = (ext_w(mdu_opr_b, word_md, 1'b0) == '0);
      // Only the most negative value has a magnitude equal to the sign bit.
      div_ovf  = (mdu_op_div | mdu_op_rem) & a_neg & (a_mag == msb_w) & (b_sx == '1);
      if (div_zero) spec_res = is_quo ? '1 : mdu_opr_a;
      else          spec_res = is_quo ? mdu_opr_a : '0;
   end

   logic [2*XLEN-1:0] acc_n, mc_n, prod;
   logic [XLEN-1:0]   mp_n, mul_res;

   always_comb begin
      acc_n = m_acc;
      mc_n  = m_mcand;
      mp_n  = m_mplr;
      for (int i = 0; i < MUL_BPC; i++) begin
         if (mp_n[0]) acc_n = acc_n + mc_n;
         mc_n = mc_n << 1;
         mp_n = mp_n >> 1;
      end
      prod = neg_q ? -acc_n : acc_n;
      if (mdu_op_mul)   mul_res = prod[XLEN-1:0];
      else if (word_md) mul_res = prod[XLEN+31:32];
      else              mul_res = prod[2*XLEN-1:XLEN];
   end

   logic [XLEN:0]   rem_sh, rem_sub;
   logic [XLEN-1:0] quo_n, rem_n, div_res;

   always_comb begin
      rem_sh  = {d_rem, d_quo[XLEN-1]};
      rem_sub = rem_sh - {1'b0, d_dvsr};
      if (rem_sub[XLEN]) begin
         rem_n = rem_sh[XLEN-1:0];
         quo_n = {d_quo[XLEN-2:0], 1'b0};
      end else begin
         rem_n = rem_sub[XLEN-1:0];
         quo_n = {d_quo[XLEN-2:0], 1'b1};
      end
      if (is_quo) div_res = neg_q ? -quo_n : quo_n;
      else        div_res = neg_r ? -rem_n : rem_n;
   end

   logic [6:0] mul_last, div_last;
   assign mul_last = word_md ? 7'(32 / MUL_BPC - 1) : 7'(XLEN / MUL_BPC - 1);
   assign div_last = word_md ? 7'd31 : 7'(XLEN - 1);

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         mdu_result <= '0;
         m_acc      <= '0;
         m_mcand    <= '0;
         m_mplr     <= '0;
         d_quo      <= '0;
         d_rem      <= '0;
         d_dvsr     <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
      end else if (abort) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mdu_valid && is_mul) begin
                  m_acc   <= '0;
                  m_mcand <= {{XLEN{1'b0}}, a_mag};
                  m_mplr  <= b_mag;
                  neg_q   <= a_neg ^ b_neg;
                  cnt     <= '0;
                  state   <= ST_MUL;
               end else if (mdu_valid && is_div) begin
                  if (div_zero || div_ovf) begin
                     mdu_result <= ext_w(spec_res, word_md, 1'b1);
                     state      <= ST_DONE;
                  end else begin
                     // Word dividends sit in the top half so the MSB shifts out first.
                     d_quo  <= word_md ? (a_mag << (XLEN - 32)) : a_mag;
                     d_rem  <= '0;
                     d_dvsr <= b_mag;
                     neg_q  <= a_neg ^ b_neg;
                     neg_r  <= a_neg;
                     cnt    <= '0;
                     state  <= ST_DIV;
                  end
               end
            end
            ST_MUL: begin
               m_acc   <= acc_n;
               m_mcand <= mc_n;
               m_mplr  <= mp_n;
               cnt     <= cnt + 7'd1;
               if (cnt == mul_last) begin
                  mdu_result <= ext_w(mul_res, word_md, 1'b1);
                  state      <= ST_DONE;
               end
            end
            ST_DIV: begin
               d_quo <= quo_n;
               d_rem <= rem_n;
               cnt   <= cnt + 7'd1;
               if (cnt == div_last) begin
                  mdu_result <= ext_w(div_res, word_md, 1'b1);
                  state      <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_pipe_exec_mdu.sv
// Bench for core_pipe_exec_mdu: two instances (1 and 4 mul bits/cycle) on shared inputs,
// expected result/latency pushed to a scoreboard queue at issue, popped at mdu_ready.
module tb_core_pipe_exec_mdu;

   localparam int OP_MUL = 0, OP_MULH = 1, OP_MULHSU = 2, OP_MULHU = 3;
   localparam int OP_DIV = 4, OP_DIVU = 5, OP_REM = 6, OP_REMU = 7;

   logic        g_clk = 1'b0;
   logic        g_reset = 1'b1;
   logic        mdu_valid = 1'b0;
   logic        mdu_flush = 1'b0;
   logic [7:0]  op_sel = '0;
   logic        mdu_word = 1'b0;
   logic [63:0] mdu_opr_a = '0;
   logic [63:0] mdu_opr_b = '0;
   logic        rdy1, rdy4;
   logic [63:0] res1, res4;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   typedef struct {
      logic [63:0] res;
      int          lat;
   } exp_t;
   exp_t sb[$];

   always #5 g_clk = ~g_clk;
   always @(posedge g_clk) cyc++;

   core_pipe_exec_mdu #(.XLEN(64), .MUL_BPC(1)) u_mdu1 (
      .g_clk(g_clk), .g_reset(g_reset), .mdu_valid(mdu_valid), .mdu_flush(mdu_flush),
      .mdu_op_mul(op_sel[0]), .mdu_op_mulh(op_sel[1]), .mdu_op_mulhsu(op_sel[2]),
      .mdu_op_mulhu(op_sel[3]), .mdu_op_div(op_sel[4]), .mdu_op_divu(op_sel[5]),
      .mdu_op_rem(op_sel[6]), .mdu_op_remu(op_sel[7]), .mdu_word(mdu_word),
      .mdu_opr_a(mdu_opr_a), .mdu_opr_b(mdu_opr_b), .mdu_ready(rdy1), .mdu_result(res1));

   core_pipe_exec_mdu #(.XLEN(64), .MUL_BPC(4)) u_mdu4 (
      .g_clk(g_clk), .g_reset(g_reset), .mdu_valid(mdu_valid), .mdu_flush(mdu_flush),
      .mdu_op_mul(op_sel[0]), .mdu_op_mulh(op_sel[1]), .mdu_op_mulhsu(op_sel[2]),
      .mdu_op_mulhu(op_sel[3]), .mdu_op_div(op_sel[4]), .mdu_op_divu(op_sel[5]),
      .mdu_op_rem(op_sel[6]), .mdu_op_remu(op_sel[7]), .mdu_word(mdu_word),
      .mdu_opr_a(mdu_opr_a), .mdu_opr_b(mdu_opr_b), .mdu_ready(rdy4), .mdu_result(res4));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic unit_rdy(input int unit);
      return unit != 0 ? rdy4 : rdy1;
   endfunction

   function automatic logic [63:0] unit_res(input int unit);
      return unit != 0 ? res4 : res1;
   endfunction

   function automatic logic [63:0] min_w(input logic wd);
      return wd ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
   endfunction

   // Reference model built on native SV arithmetic.
   function automatic logic [63:0] model(input int op, input logic wd,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [63:0]  au, bu, as_, bs, r;
      logic [127:0] p;
      longint       sa, sbv;
      logic         ovf;
      au  = wd ? {32'b0, a[31:0]} : a;
      bu  = wd ? {32'b0, b[31:0]} : b;
      as_ = wd ? {{32{a[31]}}, a[31:0]} : a;
      bs  = wd ? {{32{b[31]}}, b[31:0]} : b;
      sa  = as_;
      sbv = bs;
      ovf = (as_ == min_w(wd)) && (bs == 64'hFFFF_FFFF_FFFF_FFFF);
      r   = '0;
      case (op)
         OP_MUL:    begin p = {64'b0, au} * {64'b0, bu}; r = p[63:0]; end
         OP_MULH:   p = {{64{as_[63]}}, as_} * {{64{bs[63]}}, bs};
         OP_MULHSU: p = {{64{as_[63]}}, as_} * {64'b0, bu};
         OP_MULHU:  p = {64'b0, au} * {64'b0, bu};
         OP_DIV:    r = (bu == 0) ? '1 : ovf ? as_ : 64'(sa / sbv);
         OP_DIVU:   r = (bu == 0) ? '1 : au / bu;
         OP_REM:    r = (bu == 0) ? as_ : ovf ? '0 : 64'(sa % sbv);
         default:   r = (bu == 0) ? au : au % bu;
      endcase
      if (op == OP_MULH || op == OP_MULHSU || op == OP_MULHU)
         r = wd ? {32'b0, p[63:32]} : p[127:64];
      return wd ? {{32{r[31]}}, r[31:0]} : r;
   endfunction

   function automatic int exp_lat(input int unit, input int op, input logic wd,
                                  input logic [63:0] a, input logic [63:0] b);
      int w;
      logic [63:0] as_, bs;
      w   = wd ? 32 : 64;
      as_ = wd ? {{32{a[31]}}, a[31:0]} : a;
      bs  = wd ? {{32{b[31]}}, b[31:0]} : b;
      if (op < OP_DIV) return w / (unit != 0 ? 4 : 1) + 1;
      if ((wd ? (b[31:0] == 0) : (b == 0)) ||
          ((op == OP_DIV || op == OP_REM) && as_ == min_w(wd) && bs == '1)) return 1;
      return w + 1;
   endfunction

   // Called at a negedge with the unit idle; returns at a negedge.
   task automatic do_op(input int unit, input int op, input logic wd, input logic [63:0] a,
                        input logic [63:0] b, input bit hold, input string tag);
      exp_t e;
      int   n;
      bit   seen;
      e.res = model(op, wd, a, b);
      e.lat = exp_lat(unit, op, wd, a, b);
      sb.push_back(e);
      op_sel    = 8'(1) << op;
      mdu_word  = wd;
      mdu_opr_a = a;
      mdu_opr_b = b;
      mdu_valid = 1'b1;
      #1 chk($sformatf("%s_c0rdy", tag), 64'(unit_rdy(unit)), 64'd0);
      n    = 0;
      seen = 0;
      while (!seen && n < 200) begin
         @(posedge g_clk);
         @(negedge g_clk);
         n++;
         if (unit_rdy(unit)) seen = 1;
      end
      e = sb.pop_front();
      chk($sformatf("%s_lat", tag), 64'(n), 64'(e.lat));
      chk($sformatf("%s_res", tag), unit_res(unit), e.res);
      if (!hold) begin
         mdu_valid = 1'b0;
         op_sel    = '0;
         @(negedge g_clk);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] prev, a, b;
      bit          seen;
      int          c0, op, u;
      logic        wd;

      repeat (2) @(posedge g_clk);
      @(negedge g_clk);
      chk("rst_res1", res1, 64'd0);
      chk("rst_res4", res4, 64'd0);
      chk("rst_rdy_noop", 64'(rdy1), 64'd1);
      op_sel = 8'h01;
      #1 chk("rst_rdy_opsel", 64'(rdy1), 64'd0);
      op_sel = '0;
      @(negedge g_clk);
      g_reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         mdu_valid = i[0];
         @(negedge g_clk);
         chk("noop_rdy1", 64'(rdy1), 64'd1);
         chk("noop_rdy4", 64'(rdy4), 64'd1);
      end
      mdu_valid = 1'b0;

      for (int u2 = 0; u2 < 2; u2++) begin
         do_op(u2, OP_MUL,    0, 64'd7, -64'sd3, 0, "mul");
         do_op(u2, OP_MULH,   0, '1, '1, 0, "mulh");
         do_op(u2, OP_MULHU,  0, '1, 64'd2, 0, "mulhu");
         do_op(u2, OP_MULHSU, 0, '1, 64'd2, 0, "mulhsu");
         do_op(u2, OP_MUL,    1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_0001_0003, 0, "mulw");
         do_op(u2, OP_MULH,   1, 64'h0000_0000_8000_0001, 64'h0000_0000_7FFF_FFFF, 0, "mulhw");
      end

      do_op(0, OP_DIVU, 0, 64'd5, 64'd0, 0, "divu_z");
      do_op(0, OP_REMU, 0, 64'd5, 64'd0, 0, "remu_z");
      do_op(0, OP_DIV,  0, 64'h8000_0000_0000_0000, '1, 0, "div_ovf");
      do_op(0, OP_REM,  0, 64'h8000_0000_0000_0000, '1, 0, "rem_ovf");
      do_op(0, OP_DIV,  1, 64'h0000_0000_8000_0007, -64'sd2, 0, "divw");
      do_op(0, OP_REM,  1, 64'h0000_0000_8000_0007, -64'sd2, 0, "remw");
      do_op(0, OP_REM,  0, -64'sd100, 64'd7, 0, "rem_neg");

      // flush in cycle 10 of a divide
      prev      = res1;
      op_sel    = 8'(1) << OP_DIV;
      mdu_opr_a = 64'd100;
      mdu_opr_b = 64'd7;
      mdu_word  = 1'b0;
      mdu_valid = 1'b1;
      seen      = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge g_clk);
         @(negedge g_clk);
         if (rdy1) seen = 1;
      end
      mdu_flush = 1'b1;
      @(posedge g_clk);
      @(negedge g_clk);
      mdu_flush = 1'b0;
      mdu_valid = 1'b0;
      op_sel    = '0;
      #1 chk("flush_idle", 64'(rdy1), 64'd1);
      chk("flush_noready", 64'(seen), 64'd0);
      chk("flush_res_held", res1, prev);
      @(negedge g_clk);
      do_op(0, OP_MUL, 0, 64'd6, 64'd7, 0, "mul_after_flush");

      // back-to-back with valid held
      c0 = cyc;
      do_op(0, OP_DIV, 0, 64'd100, 64'd7, 1, "b2b_div");
      @(negedge g_clk);
      do_op(0, OP_REM, 0, 64'd100, 64'd7, 0, "b2b_rem");
      chk("b2b_abs_cycle", 64'(cyc - c0 - 1), 64'd131);

      // valid dropped mid-op
      prev      = res1;
      op_sel    = 8'(1) << OP_MUL;
      mdu_opr_a = 64'd3;
      mdu_opr_b = 64'd5;
      mdu_valid = 1'b1;
      seen      = 0;
      repeat (20) @(negedge g_clk);
      mdu_valid = 1'b0;
      for (int k = 0; k < 70; k++) begin
         @(negedge g_clk);
         if (rdy1) seen = 1;
      end
      chk("vdrop_noready", 64'(seen), 64'd0);
      chk("vdrop_res_held", res1, prev);
      op_sel = '0;
      @(negedge g_clk);

      // synchronous reset mid-operation
      op_sel    = 8'(1) << OP_MUL;
      mdu_valid = 1'b1;
      repeat (5) @(negedge g_clk);
      g_reset = 1'b1;
      @(negedge g_clk);
      g_reset   = 1'b0;
      mdu_valid = 1'b0;
      op_sel    = '0;
      #1 chk("midrst_res", res1, 64'd0);
      chk("midrst_rdy", 64'(rdy1), 64'd1);
      @(negedge g_clk);

      for (int i = 0; i < 24; i++) begin
         op = int'($urandom_range(0, 7));
         wd = 1'($urandom_range(0, 1));
         u  = i % 2;
         a  = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0:       b = wd ? {$urandom, 32'h0} : 64'h0;
            1:       begin a = min_w(wd); b = '1; end
            2:       b = 64'($urandom_range(1, 20));
            default: b = {$urandom, $urandom};
         endcase
         do_op(u, op, wd, a, b, 0, $sformatf("rnd%0d_op%0d_w%0d", i, op, wd));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
